lsu_mem_master: RTL and testbench

Load/store unit that initiates all data-memory traffic from the CPU pipeline onto the word-only memory port (mem_rd, mem_wr, mem_addr, mem_wr_data, mem_rd_data). It accepts one lb/lbu/lh/lhu/lw/sb/sh/sw request at a time and checks alignment and range. It converts sub-word stores into a read-modify-write sequence. Load results are extracted and sign- or zero-extended before being returned to the pipeline.

---
 rtl/lsu_mem_master.sv | 172 +++++++++++++++++
 tb/tb_lsu_mem_master.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_master.sv
// Load/store unit for a word-only data memory port: alignment/range checks,
// sub-word loads with extension, and sub-word stores done as read-modify-write.
module lsu_mem_master #(
  parameter int MEM_BYTES  = 4096,
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic        lsu_clk,
  input  logic        lsu_rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic        resp_err,
  output logic [31:0] resp_rdata,
  output logic [31:0] mem_addr,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [31:0] mem_wr_data,
  input  logic [31:0] mem_rd_data,
  output logic [2:0]  dbg_state
);

  // Request handshake: a request transfers on a rising edge where req_valid
  // and req_ready are both 1; req_ready is 1 only in IDLE.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    RMW_RD = 3'd2,
    WRITE  = 3'd3,
    DONE   = 3'd4
  } state_t;

  localparam logic [31:0] MEM_LIMIT = 32'(MEM_BYTES);

  state_t      state;
  logic [1:0]  lat_size;
  logic        lat_signed;
  logic [1:0]  lat_off;
  logic [31:0] lat_wdata;
  logic        err_q;
  logic        ready_q;
  logic        resp_valid_q;
  logic [31:0] resp_rdata_q;
  logic [31:0] mem_addr_q;
  logic        mem_rd_q;
  logic        mem_wr_q;
  logic [31:0] mem_wr_data_q;

  logic        req_err;
  logic [4:0]  shift;
  logic [31:0] lane_word;
  logic [31:0] load_val;
  logic [31:0] lane_mask;
  logic [31:0] merge_word;

  // Bit position of the addressed lane inside the memory word.
  function automatic logic [4:0] lane_shift(input logic [1:0] size, input logic [1:0] off);
    logic [1:0] lane;
    lane = 2'b00;
    if (size == 2'b00) lane = BIG_ENDIAN ? ~off : off;
    else if (size == 2'b01) lane = BIG_ENDIAN ? {~off[1], 1'b0} : {off[1], 1'b0};
    return {lane, 3'b000};
  endfunction

  always_comb begin
    req_err = (req_size == 2'b11) ||
              ((req_size == 2'b01) && req_addr[0]) ||
              ((req_size == 2'b10) && (req_addr[1:0] != 2'b00)) ||
              (req_addr >= MEM_LIMIT);
    shift     = lane_shift(lat_size, lat_off);
    lane_word = mem_rd_data >> shift;
    case (lat_size)
      2'b00:   load_val = {{24{lat_signed & lane_word[7]}}, lane_word[7:0]};
      2'b01:   load_val = {{16{lat_signed & lane_word[15]}}, lane_word[15:0]};
      default: load_val = lane_word;
    endcase
    lane_mask  = (lat_size == 2'b00) ? (32'h0000_00FF << shift) : (32'h0000_FFFF << shift);
    merge_word = (mem_rd_data & ~lane_mask) | ((lat_wdata << shift) & lane_mask);
  end

  always_ff @(posedge lsu_clk) begin
    if (lsu_rst) begin
      state         <= IDLE;
      lat_size      <= 2'b00;
      lat_signed    <= 1'b0;
      lat_off       <= 2'b00;
      lat_wdata     <= 32'h0;
      err_q         <= 1'b0;
      ready_q       <= 1'b1;
      resp_valid_q  <= 1'b0;
      resp_rdata_q  <= 32'h0;
      mem_addr_q    <= 32'h0;
      mem_rd_q      <= 1'b0;
      mem_wr_q      <= 1'b0;
      mem_wr_data_q <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            lat_size   <= req_size;
            lat_signed <= req_signed;
            lat_off    <= req_addr[1:0];
            lat_wdata  <= req_wdata;
            mem_addr_q <= {req_addr[31:2], 2'b00};
            ready_q    <= 1'b0;
            err_q      <= req_err;
            if (req_err) begin
              resp_valid_q <= 1'b1;
              resp_rdata_q <= 32'h0;
              state        <= DONE;
            end else if (!req_we) begin
              mem_rd_q <= 1'b1;
              state    <= LOAD;
            end else if (req_size == 2'b10) begin
              mem_wr_q      <= 1'b1;
              mem_wr_data_q <= req_wdata;
              state         <= WRITE;
            end else begin
              mem_rd_q <= 1'b1;
              state    <= RMW_RD;
            end
          end
        end
        LOAD: begin
          mem_rd_q     <= 1'b0;
          resp_rdata_q <= load_val;
          resp_valid_q <= 1'b1;
          state        <= DONE;
        end
        RMW_RD: begin
          mem_rd_q      <= 1'b0;
          mem_wr_q      <= 1'b1;
          mem_wr_data_q <= merge_word;
          state         <= WRITE;
        end
        WRITE: begin
          mem_wr_q      <= 1'b0;
          mem_wr_data_q <= 32'h0;
          resp_rdata_q  <= 32'h0;
          resp_valid_q  <= 1'b1;
          state         <= DONE;
        end
        DONE: begin
          resp_valid_q <= 1'b0;
          mem_addr_q   <= 32'h0;
          ready_q      <= 1'b1;
          state        <= IDLE;
        end
        default: begin
          state   <= IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  // The write strobe is cut by reset so a reset landing on WRITE never commits.
  assign mem_wr      = mem_wr_q & ~lsu_rst;
  assign mem_rd      = mem_rd_q;
  assign mem_wr_data = mem_wr_data_q;
  assign mem_addr    = mem_addr_q;
  assign req_ready   = ready_q;
  assign resp_valid  = resp_valid_q;
  assign resp_err    = resp_valid_q & err_q;
  assign resp_rdata  = resp_rdata_q;
  assign dbg_state   = state;

endmodule

// File: tb/tb_lsu_mem_master.sv
// Bench for lsu_mem_master: byte-array reference model feeds an expected
// queue; a negedge monitor checks every response against it.
module tb_lsu_mem_master;
  localparam int MEM_BYTES = 4096;
  localparam bit BE = 1'b1;

  logic        lsu_clk, lsu_rst;
  logic        req_valid, req_ready, req_we, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata, mem_addr, mem_wr_data, mem_rd_data;
  logic        mem_rd, mem_wr;
  logic [2:0]  dbg_state;

  lsu_mem_master #(.MEM_BYTES(MEM_BYTES), .BIG_ENDIAN(BE)) dut (
    .lsu_clk(lsu_clk), .lsu_rst(lsu_rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_err(resp_err),
    .resp_rdata(resp_rdata), .mem_addr(mem_addr), .mem_rd(mem_rd),
    .mem_wr(mem_wr), .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data),
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial lsu_clk = 1'b0;
  always #5 lsu_clk = ~lsu_clk;

  // memory seen by the DUT, with a backdoor write port for preloading
  logic [31:0] dut_mem [0:1023];
  logic        bd_we;
  logic [9:0]  bd_idx;
  logic [31:0] bd_data;
  assign mem_rd_data = dut_mem[mem_addr[11:2]];
  always @(posedge lsu_clk) begin
    if (mem_wr) dut_mem[mem_addr[11:2]] <= mem_wr_data;
    else if (bd_we) dut_mem[bd_idx] <= bd_data;
  end

  // reference model state: plain byte array
  logic [7:0]  ref_b [0:MEM_BYTES-1];
  logic [32:0] exp_q [$];
  int          n_cmp, n_bad;
  bit          act_flag, overlap;

  task automatic chk(input string name, input logic [32:0] act, input logic [32:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_word(input int w);
    logic [31:0] v;
    v = 32'h0;
    for (int i = 0; i < 4; i++) v = (v << 8) | 32'(ref_b[4*w + (BE ? i : 3 - i)]);
    return v;
  endfunction

  task automatic set_word(input int byte_addr, input logic [31:0] v);
    int w;
    w = byte_addr / 4;
    for (int i = 0; i < 4; i++) ref_b[4*w + (BE ? i : 3 - i)] = v[31 - 8*i -: 8];
    bd_idx  = 10'(w);
    bd_data = v;
    bd_we   = 1'b1;
    @(posedge lsu_clk); #1;
    bd_we   = 1'b0;
  endtask

  // behavioural reference: byte addressing, sign extension by subtraction
  task automatic model_req(input logic we, input logic [1:0] size, input logic sgn,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           output logic [32:0] e, output int lat);
    int a, nb;
    logic [31:0] v;
    longint lim;
    bit err;
    err = (size == 2'd3) || (size == 2'd1 && addr % 2 != 0) ||
          (size == 2'd2 && addr % 4 != 0) || (addr >= 32'(MEM_BYTES));
    if (err) begin
      e = {1'b1, 32'h0};
      lat = 1;
    end else begin
      a  = int'(addr);
      nb = 1 << size;
      if (!we) begin
        v = 32'h0;
        for (int i = 0; i < nb; i++) v = (v << 8) | 32'(ref_b[a + (BE ? i : nb - 1 - i)]);
        lim = longint'(1) << (8 * nb);
        if (sgn && nb < 4 && longint'(v) >= lim / 2) v = v - 32'(lim);
        e = {1'b0, v};
        lat = 2;
      end else begin
        for (int i = 0; i < nb; i++) ref_b[a + (BE ? i : nb - 1 - i)] = 8'(wdata >> (8 * (nb - 1 - i)));
        e = {1'b0, 32'h0};
        lat = (size == 2'd2) ? 2 : 3;
      end
    end
  endtask

  // driver: issues one request, checks accept-to-response latency
  task automatic do_req(input logic we, input logic [1:0] size, input logic sgn,
                        input logic [31:0] addr, input logic [31:0] wdata, input bit junk);
    logic [32:0] e;
    int lat, k, guard;
    model_req(we, size, sgn, addr, wdata, e, lat);
    exp_q.push_back(e);
    req_we = we; req_size = size; req_signed = sgn; req_addr = addr; req_wdata = wdata;
    req_valid = 1'b1;
    guard = 0;
    while (!req_ready && guard < 20) begin
      @(posedge lsu_clk); #1;
      guard++;
    end
    if (!req_ready) begin
      n_cmp++; n_bad++;
      $display("FAIL accept_timeout: req_ready stayed 0 for %0d cycles", guard);
    end
    act_flag = 1'b0;
    @(posedge lsu_clk); #1;
    k = 1;
    if (!junk) req_valid = 1'b0;
    while (!resp_valid && k < 8) begin
      if (junk) begin
        req_we = 1'($urandom); req_size = 2'($urandom); req_signed = 1'($urandom);
        req_addr = $urandom_range(0, 255); req_wdata = $urandom;
      end
      @(posedge lsu_clk); #1;
      k++;
    end
    req_valid = 1'b0;
    chk("latency", 33'(k), 33'(lat));
    if (e[32]) chk("err_no_mem_access", 33'(act_flag), 33'd0);
  endtask

  // monitor
  always @(negedge lsu_clk) begin
    if (!lsu_rst) begin
      if (mem_rd && mem_wr) overlap = 1'b1;
      if (mem_rd || mem_wr) act_flag = 1'b1;
      if (resp_valid) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_resp: err=%b rdata=%h with empty queue", resp_err, resp_rdata);
        end else begin
          chk("resp", {resp_err, resp_rdata}, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [1:0] sz;
    logic [31:0] ad;
    n_cmp = 0; n_bad = 0; act_flag = 1'b0; overlap = 1'b0;
    bd_we = 1'b0; bd_idx = 10'h0; bd_data = 32'h0;
    req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_signed = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0;
    for (int i = 0; i < MEM_BYTES; i++) ref_b[i] = 8'h0;
    lsu_rst = 1'b1;
    for (int w = 0; w < 16; w++) set_word(4 * w, $urandom);
    set_word(32'h10, 32'h8122F344);
    for (int w = 16; w < 1024; w++) set_word(4 * w, 32'h0);

    // reset state
    chk("rst_req_ready", 33'(req_ready), 33'd1);
    chk("rst_resp_valid", 33'(resp_valid), 33'd0);
    chk("rst_mem_rd_wr", 33'({mem_rd, mem_wr}), 33'd0);
    chk("rst_resp_rdata", 33'(resp_rdata), 33'd0);
    chk("rst_mem_addr", 33'(mem_addr), 33'd0);
    lsu_rst = 1'b0;

    // directed loads on 0x8122F344 @0x10
    do_req(1'b0, 2'd0, 1'b1, 32'h10, 32'h0, 1'b0);
    do_req(1'b0, 2'd0, 1'b0, 32'h10, 32'h0, 1'b0);
    do_req(1'b0, 2'd1, 1'b1, 32'h12, 32'h0, 1'b0);
    do_req(1'b0, 2'd1, 1'b0, 32'h12, 32'h0, 1'b0);
    do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b0);
    chk("lw_0x10_value", 33'(resp_rdata), 33'h0_8122F344);

    // sub-word store via read-modify-write
    do_req(1'b1, 2'd0, 1'b0, 32'h11, 32'h000000AB, 1'b0);
    @(posedge lsu_clk); #1;
    chk("sb_word_0x10", 33'(dut_mem[4]), 33'h0_81ABF344);

    // error cases
    do_req(1'b0, 2'd2, 1'b0, 32'h12, 32'h0, 1'b0);
    do_req(1'b0, 2'd1, 1'b0, 32'h13, 32'h0, 1'b0);
    do_req(1'b0, 2'd3, 1'b0, 32'h10, 32'h0, 1'b0);
    do_req(1'b0, 2'd2, 1'b0, 32'h1000, 32'h0, 1'b0);
    do_req(1'b1, 2'd1, 1'b0, 32'h11, 32'h5555, 1'b0);

    // store then immediate load
    do_req(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0);
    do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b0);
    chk("sw_lw_value", 33'(resp_rdata), 33'h0_DEADBEEF);

    // reset landing on the WRITE cycle of a half store
    @(posedge lsu_clk); #1;
    set_word(32'h10, 32'h8122F344);
    req_we = 1'b1; req_size = 2'd1; req_signed = 1'b0; req_addr = 32'h10; req_wdata = 32'h1234;
    req_valid = 1'b1;
    @(posedge lsu_clk); #1;
    req_valid = 1'b0;
    @(posedge lsu_clk); #1;
    chk("write_strobe", 33'(mem_wr), 33'd1);
    lsu_rst = 1'b1;
    @(posedge lsu_clk); #1;
    lsu_rst = 1'b0;
    chk("rst_write_word", 33'(dut_mem[4]), 33'h0_8122F344);
    chk("rst_write_state", 33'(dbg_state), 33'd0);
    chk("rst_write_ready", 33'(req_ready), 33'd1);
    chk("rst_write_resp", 33'(resp_valid), 33'd0);

    // inputs change while busy
    do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b1);
    do_req(1'b1, 2'd0, 1'b0, 32'h13, 32'h000000C7, 1'b1);
    do_req(1'b0, 2'd1, 1'b1, 32'h12, 32'h0, 1'b1);

    // randomized traffic
    for (int n = 0; n < 300; n++) begin
      sz = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 15) == 0) ad = $urandom_range(MEM_BYTES, MEM_BYTES + 300);
      else ad = $urandom_range(0, 63);
      do_req(1'($urandom), sz, 1'($urandom), ad, $urandom, 1'($urandom_range(0, 3) == 0));
    end

    repeat (3) @(posedge lsu_clk);
    #1;
    chk("exp_q_drained", 33'(exp_q.size()), 33'd0);
    chk("rd_wr_overlap", 33'(overlap), 33'd0);
    for (int w = 0; w < 16; w++) chk("mem_final", 33'(dut_mem[w]), 33'(ref_word(w)));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
